// File: rtl/pot_scheduler.sv
// Round-robin scheduler for the six slider pots behind the A2D converter.
// One conversion per slot: START pulses strt_cnv, WAIT collects the result
// (or abandons it after TIMEOUT cycles), GAP idles before the next slot.
//
// state | meaning
// IDLE  | scanning stopped, waiting for scan_en
// START | one-cycle strt_cnv pulse on the current slot's channel
// WAIT  | waiting for cnv_cmplt, bounded by TIMEOUT cycles
// GAP   | GAP_CYCLES idle cycles, then advance the slot
module pot_scheduler #(
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic        err_clr,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] volume,
  output logic [2:0]  slot,
  output logic        pot_vld,
  output logic        tmo_err
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [2:0]          slot_d;
  logic                capture, timeout, end_slot;
  logic [5:0]          loaded_q, loaded_d;
  logic [11:0]         pot_q [6];

  function automatic logic [2:0] chan_of(input logic [2:0] s);
    case (s)
      3'd0:    chan_of = 3'd1;
      3'd1:    chan_of = 3'd0;
      3'd2:    chan_of = 3'd4;
      3'd3:    chan_of = 3'd2;
      3'd4:    chan_of = 3'd3;
      3'd5:    chan_of = 3'd7;
      default: chan_of = 3'd1;
    endcase
  endfunction

  // Next-state, counters and slot advance; a completion beats a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    capture    = 1'b0;
    timeout    = 1'b0;
    end_slot   = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_en) state_d = START;
      end
      START: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (cnv_cmplt)                     capture = 1'b1;
        else if (wait_cnt_q == WAIT_LAST)  timeout = 1'b1;
        if (capture || timeout) begin
          if (GAP_CYCLES == 0) begin
            end_slot = 1'b1;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) end_slot  = 1'b1;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (end_slot) begin
      slot_d  = (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      state_d = scan_en ? START : IDLE;
    end
  end

  // Loaded bits including this cycle's capture, so pot_vld rises with the data.
  always_comb begin
    loaded_d = loaded_q;
    if (capture) loaded_d[slot] = 1'b1;
  end

  // FSM state, counters, slot and the registered channel/start decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot       <= 3'd0;
      chnnl      <= 3'b001;
      strt_cnv   <= 1'b0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot       <= slot_d;
      chnnl      <= chan_of(slot_d);
      strt_cnv   <= (state_d == START);
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Result capture, valid tracking and the sticky timeout flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) pot_q[i] <= '0;
      loaded_q <= '0;
      pot_vld  <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      if (capture) pot_q[slot] <= res;
      loaded_q <= loaded_d;
      pot_vld  <= pot_vld | (&loaded_d);
      if (timeout)      tmo_err <= 1'b1;
      else if (err_clr) tmo_err <= 1'b0;
    end
  end

  assign LP_pot = pot_q[0];
  assign B1_pot = pot_q[1];
  assign B2_pot = pot_q[2];
  assign B3_pot = pot_q[3];
  assign HP_pot = pot_q[4];
  assign volume = pot_q[5];

endmodule

// File: tb/tb_pot_scheduler.sv
// Bench for pot_scheduler: a GAP=64/TIMEOUT=1024 instance for the directed
// table and reset cases, and a GAP=0/TIMEOUT=12 instance for random scanning.
module tb_pot_scheduler;

  localparam int G_MAIN = 64;
  localparam int T_MAIN = 1024;
  localparam int G_FAST = 0;
  localparam int T_FAST = 12;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, scan_en, cnv_cmplt, err_clr;
  logic [11:0] res;
  logic        rst_d, rst_f;
  assign rst_d = rst_n & ~sel;
  assign rst_f = rst_n & sel;

  logic             d_strt, f_strt, d_vld, f_vld, d_tmo, f_tmo;
  logic [2:0]       d_ch, f_ch, d_slot, f_slot;
  logic [5:0][11:0] d_pot, f_pot;

  pot_scheduler #(.GAP_CYCLES(G_MAIN), .TIMEOUT(T_MAIN)) u_dut (
    .clk(clk), .rst_n(rst_d), .scan_en(scan_en), .cnv_cmplt(cnv_cmplt), .res(res),
    .err_clr(err_clr), .strt_cnv(d_strt), .chnnl(d_ch),
    .LP_pot(d_pot[0]), .B1_pot(d_pot[1]), .B2_pot(d_pot[2]), .B3_pot(d_pot[3]),
    .HP_pot(d_pot[4]), .volume(d_pot[5]), .slot(d_slot), .pot_vld(d_vld), .tmo_err(d_tmo)
  );

  pot_scheduler #(.GAP_CYCLES(G_FAST), .TIMEOUT(T_FAST)) u_fast (
    .clk(clk), .rst_n(rst_f), .scan_en(scan_en), .cnv_cmplt(cnv_cmplt), .res(res),
    .err_clr(err_clr), .strt_cnv(f_strt), .chnnl(f_ch),
    .LP_pot(f_pot[0]), .B1_pot(f_pot[1]), .B2_pot(f_pot[2]), .B3_pot(f_pot[3]),
    .HP_pot(f_pot[4]), .volume(f_pot[5]), .slot(f_slot), .pot_vld(f_vld), .tmo_err(f_tmo)
  );

  logic             strt, vld, tmo;
  logic [2:0]       ch, slot_o;
  logic [5:0][11:0] pot;
  always_comb begin
    strt   = sel ? f_strt : d_strt;
    ch     = sel ? f_ch   : d_ch;
    slot_o = sel ? f_slot : d_slot;
    pot    = sel ? f_pot  : d_pot;
    vld    = sel ? f_vld  : d_vld;
    tmo    = sel ? f_tmo  : d_tmo;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " strt_cnv"}, strt, 0);
    chk({tag, " chnnl"}, ch, 1);
    chk({tag, " slot"}, slot_o, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("%s pot%0d", tag, i), pot[i], 0);
    chk({tag, " pot_vld"}, vld, 0);
    chk({tag, " tmo_err"}, tmo, 0);
  endtask

  // act: 0 none, 1 err_clr pulse in GAP, 2 err_clr on the last WAIT cycle,
  //      3 spurious cnv_cmplt in GAP. lat outside 1..tlim means no completion.
  task automatic run_conv(input string tag, input int lat, input logic [11:0] val,
                          input logic [2:0] exp_ch, input int exp_slot,
                          input logic [11:0] exp_pot, input bit exp_tmo, input bit exp_vld,
                          input int act, input int gap, input int tlim);
    int n;
    int last;
    bit bad;
    n = 0;
    while (!strt && n < 2000) begin @(negedge clk); n++; end
    if (!strt) begin
      chk({tag, " start_seen"}, strt, 1);
      return;
    end
    chk({tag, " chnnl"}, ch, exp_ch);
    chk({tag, " slot"}, slot_o, exp_slot);
    res  = ~val;
    last = (lat >= 1 && lat <= tlim) ? lat : tlim;
    bad  = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (strt || ch !== exp_ch) bad = 1'b1;
      if (k == last && act == 2) err_clr = 1'b1;
      if (k == lat) begin cnv_cmplt = 1'b1; res = val; end
    end
    @(negedge clk);
    cnv_cmplt = 1'b0; err_clr = 1'b0; res = ~val;
    chk({tag, " wait_stable"}, bad, 0);
    chk({tag, " pot"}, pot[exp_slot], exp_pot);
    chk({tag, " tmo_err"}, tmo, exp_tmo);
    chk({tag, " pot_vld"}, vld, exp_vld);
    n = 0;
    while (!strt && n < gap + 8) begin
      if (act == 1 && n == 0) err_clr = 1'b1;
      if (act == 3 && n == 0) begin cnv_cmplt = 1'b1; res = 12'hEEE; end
      @(negedge clk);
      n++;
      err_clr = 1'b0; cnv_cmplt = 1'b0;
      if (act == 1 && n == 1) chk({tag, " err_clr"}, tmo, 0);
      if (act == 3 && n == 1) chk({tag, " gap_spurious"}, pot[exp_slot], exp_pot);
    end
    chk({tag, " gap_len"}, n, gap);
  endtask

  // Transaction-level reference for the random run on u_fast.
  logic [2:0]  chmap [6];
  logic [11:0] m_pot [6];
  bit          m_ld  [6];
  bit          m_tmo;
  int          m_slot;

  task automatic model_conv(input int lat, input logic [11:0] val, input int act);
    bit all;
    if (lat >= 1 && lat <= T_FAST) begin
      m_pot[m_slot] = val;
      m_ld[m_slot]  = 1'b1;
      if (act == 2) m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b1;
    end
    all = 1'b1;
    for (int i = 0; i < 6; i++) if (!m_ld[i]) all = 1'b0;
    run_conv($sformatf("rnd s%0d", m_slot), lat, val, chmap[m_slot], m_slot,
             m_pot[m_slot], m_tmo, all, act, G_FAST, T_FAST);
    m_slot = (m_slot + 1) % 6;
  endtask

  typedef struct {
    int          lat;
    logic [11:0] val;
    logic [2:0]  ch;
    int          slot;
    logic [11:0] pot;
    bit          tmo;
    bit          vld;
    int          act;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n;
    bit bad;
    tbl[0]  = '{20,   12'h0AB, 3'd1, 0, 12'h0AB, 1'b0, 1'b0, 0};
    tbl[1]  = '{20,   12'h1AB, 3'd0, 1, 12'h1AB, 1'b0, 1'b0, 0};
    tbl[2]  = '{20,   12'h2AB, 3'd4, 2, 12'h2AB, 1'b0, 1'b0, 0};
    tbl[3]  = '{20,   12'h3AB, 3'd2, 3, 12'h3AB, 1'b0, 1'b0, 0};
    tbl[4]  = '{20,   12'h4AB, 3'd3, 4, 12'h4AB, 1'b0, 1'b0, 0};
    tbl[5]  = '{20,   12'h5AB, 3'd7, 5, 12'h5AB, 1'b0, 1'b1, 0};
    tbl[6]  = '{1024, 12'h0CD, 3'd1, 0, 12'h0CD, 1'b0, 1'b1, 0};
    tbl[7]  = '{1,    12'h1CD, 3'd0, 1, 12'h1CD, 1'b0, 1'b1, 0};
    tbl[8]  = '{0,    12'h2CD, 3'd4, 2, 12'h2AB, 1'b1, 1'b1, 1};
    tbl[9]  = '{7,    12'h3CD, 3'd2, 3, 12'h3CD, 1'b0, 1'b1, 3};
    tbl[10] = '{0,    12'h4CD, 3'd3, 4, 12'h4AB, 1'b1, 1'b1, 2};
    tbl[11] = '{3,    12'h5CD, 3'd7, 5, 12'h5CD, 1'b1, 1'b1, 0};
    chmap = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    rst_n = 1'b0; sel = 1'b0; scan_en = 1'b0; cnv_cmplt = 1'b0; err_clr = 1'b0; res = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("por");

    cnv_cmplt = 1'b1; res = 12'h9A9;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    @(negedge clk);
    chk("idle_spurious LP_pot", pot[0], 0);
    chk("idle_spurious strt_cnv", strt, 0);

    scan_en = 1'b1;
    for (int i = 0; i < 12; i++)
      run_conv($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].val, tbl[i].ch, tbl[i].slot,
               tbl[i].pot, tbl[i].tmo, tbl[i].vld, tbl[i].act, G_MAIN, T_MAIN);

    // Reset pulsed in the middle of slot 0's WAIT, then a late cnv_cmplt in IDLE.
    repeat (5) @(negedge clk);
    rst_n = 1'b0; scan_en = 1'b0;
    #1;
    chk("async_rst LP_pot", pot[0], 0);
    chk("async_rst pot_vld", vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b1; res = 12'hBAD;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("mid_wait_rst");

    // Random scanning on the zero-gap instance against the transaction model.
    sel = 1'b1;
    m_slot = 0; m_tmo = 1'b0;
    for (int i = 0; i < 6; i++) begin m_pot[i] = '0; m_ld[i] = 1'b0; end
    @(negedge clk);
    scan_en = 1'b1;
    for (int i = 0; i < 120; i++)
      model_conv(int'($urandom_range(1, T_FAST + 3)), 12'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2 : 0);
    while (m_slot != 4) model_conv(5, 12'($urandom), 0);

    // scan_en drops one cycle after strt_cnv on slot 4.
    n = 0;
    while (!strt && n < 50) begin @(negedge clk); n++; end
    chk("stop start_ch", ch, 3);
    @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    cnv_cmplt = 1'b1; res = 12'h4E5;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    chk("stop HP_pot", pot[4], 12'h4E5);
    chk("stop slot", slot_o, 5);
    chk("stop chnnl", ch, 7);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin cnv_cmplt = 1'b1; res = 12'h777; end
      if (k == 6) cnv_cmplt = 1'b0;
      @(negedge clk);
      if (strt) bad = 1'b1;
    end
    chk("stop no_strt", bad, 0);
    chk("stop idle_spurious volume", pot[5], m_pot[5]);
    chk("stop idle_spurious HP_pot", pot[4], 12'h4E5);
    scan_en = 1'b1;
    n = 0;
    while (!strt && n < 10) begin @(negedge clk); n++; end
    chk("resume latency", n, 1);
    chk("resume chnnl", ch, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pot_scheduler.md
POT_SCHEDULER -- requirements
Module: pot_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 64, idle cycles between the end of one conversion and the next strt_cnv (0 = back-to-back).
REQ-002 Parameter TIMEOUT, default 1024, maximum WAIT cycles before a conversion is abandoned.
REQ-003 clk  in  1  system clock; all state on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 scan_en  in  1  level; high = keep scanning, low = stop after the current conversion.
REQ-006 cnv_cmplt  in  1  A2D interface conversion-complete pulse.
REQ-007 res  in  12  A2D result, valid while cnv_cmplt=1.
REQ-008 err_clr  in  1  pulse; clears tmo_err.
REQ-009 strt_cnv  out  1  one-cycle pulse starting an A2D conversion.
REQ-010 chnnl  out  3  A2D channel of the current slot.
REQ-011 LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume  out  12 each  latest captured slider values.
REQ-012 slot  out  3  current slot index 0..5.
REQ-013 pot_vld  out  1  high once all six registers hold a captured value.
REQ-014 tmo_err  out  1  sticky conversion-timeout flag.

Function
REQ-015 Slot-to-channel map: 0=LP/ch1, 1=B1/ch0, 2=B2/ch4, 3=B3/ch2, 4=HP/ch3, 5=volume/ch7; chnnl is a registered decode of slot.
REQ-016 FSM states: IDLE, START, WAIT, GAP; all outputs registered.
REQ-017 IDLE: scan_en=1 -> START next cycle; otherwise remain in IDLE.
REQ-018 START lasts exactly one cycle; strt_cnv=1 only in START; chnnl stays stable from START until leaving WAIT.
REQ-019 WAIT: cycle counter starts at 0 on entry and increments each cycle.
REQ-020 WAIT with cnv_cmplt=1: res is written to the slot's register on that edge (new value visible the next cycle), the slot's loaded bit is set, and the FSM goes to GAP.
REQ-021 WAIT with the counter at TIMEOUT-1 and cnv_cmplt=0: tmo_err is set, no register is written, and the FSM goes to GAP.
REQ-022 If cnv_cmplt=1 on the timeout cycle, the completion takes precedence: data is captured and tmo_err is not set.
REQ-023 cnv_cmplt outside WAIT is ignored; no register changes.
REQ-024 GAP lasts GAP_CYCLES cycles (0 = pass through in zero cycles). At its end slot advances, wrapping 5 -> 0, then START if scan_en=1, else IDLE.
REQ-025 scan_en falling mid-conversion does not abort: the current WAIT completes or times out, then GAP, then IDLE; slot still advances.
REQ-026 pot_vld is registered AND of six loaded bits; once set it stays high until reset.
REQ-027 err_clr clears tmo_err; if a timeout sets tmo_err in the same cycle, set wins.
REQ-028 Scan period per slot = 1 (START) + WAIT cycles + GAP_CYCLES; no slot skipped under any condition.

Reset
REQ-029 rst_n low asynchronously forces: IDLE, slot=0, chnnl=3'b001, strt_cnv=0, all pot registers 12'h000, loaded bits 0, pot_vld=0, tmo_err=0, counters 0.
REQ-030 Reset asserted mid-WAIT discards the pending conversion; a cnv_cmplt arriving after release, in IDLE, is ignored.

Verification
REQ-031 Reset, scan_en=1, model returns res=slot*0x100+0x0AB with 20-cycle latency -> strt_cnv pulses in order ch1,0,4,2,3,7; LP_pot=0x0AB, volume=0x5AB; pot_vld rises the cycle after slot-5 capture.
REQ-032 GAP_CYCLES=64 -> exactly 64 cycles from the capture edge to the next strt_cnv, plus one cycle for START; GAP_CYCLES=0 -> strt_cnv the cycle after capture.
REQ-033 Model withholds cnv_cmplt for slot 2 -> tmo_err rises after TIMEOUT WAIT cycles, B2_pot unchanged, next strt_cnv on ch2 (slot 3); err_clr drops tmo_err next cycle.
REQ-034 cnv_cmplt exactly on the timeout cycle -> value captured, tmo_err stays 0.
REQ-035 scan_en dropped one cycle after strt_cnv on slot 4 -> HP_pot captured, FSM IDLE with slot=5, no further strt_cnv; scan_en re-raised -> next strt_cnv on ch7.
REQ-036 Spurious cnv_cmplt in GAP and IDLE, and rst_n pulsed mid-WAIT -> no register update; all outputs at reset values.
